// File: rtl/pe_row_fp8_drain.sv
// Drain stage for the PE row: captures N_COLS BF16 words and requantizes them to FP8 E4M3 (RNE, saturating).
// It then streams the bytes out. Define FP8_SAT_CNT_EN to add the sat_count port.
module pe_row_fp8_drain #(
  parameter int N_COLS = 8,
  parameter int IDX_W  = $clog2(N_COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cap_valid,
  output logic                 cap_ready,
  input  logic [16*N_COLS-1:0] cap_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_last,
`ifdef FP8_SAT_CNT_EN
  output logic [15:0]          sat_count,
`endif
  output logic                 busy
);

  typedef enum logic {IDLE, DRAIN} state_e;

  localparam int              LastIdxI = N_COLS - 1;
  localparam logic [IDX_W:0]  NColsC   = N_COLS[IDX_W:0];
  localparam logic [IDX_W:0]  LastIdxC = LastIdxI[IDX_W:0];

  state_e           state_q, state_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [15:0]      bank_q [N_COLS];
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [IDX_W-1:0] out_col_q, out_col_d;
  logic             out_last_q, out_last_d;
  logic             out_sat_q, out_sat_d;
  logic             capFire;
  logic             accept;
  logic             loadEn;
  logic [8:0]       convWord;

  // Bit 8 of the result flags a saturated conversion; bits 7:0 are the E4M3 byte.
  function automatic logic [8:0] convert(input logic [15:0] w);
    logic              s;
    logic [7:0]        e;
    logic signed [9:0] fe;
    logic [3:0]        fm;
    logic              rnd;
    s   = w[15];
    e   = w[14:7];
    fe  = $signed({2'b00, e}) - 10'sd120;
    fm  = {1'b0, w[6:4]};
    rnd = w[3] && ((|w[2:0]) || w[4]);
    fm  = fm + {3'b000, rnd};
    if (fm[3]) begin
      fm = 4'd0;
      fe = fe + 10'sd1;
    end
    if (e == 8'd0) begin
      convert = 9'h000;
    end else if ((e == 8'hFF) || (fe > 10'sd15)) begin
      convert = {1'b1, s, 7'h7F};
    end else if (fe < 10'sd1) begin
      convert = 9'h000;
    end else begin
      convert = {1'b0, s, fe[3:0], fm[2:0]};
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    cap_ready   = (state_q == IDLE);
    capFire     = cap_valid && cap_ready;
    accept      = out_valid_q && out_ready;
    loadEn      = (state_q == DRAIN) && (!out_valid_q || out_ready) && (idx_q < NColsC);
    convWord    = convert(bank_q[idx_q[IDX_W-1:0]]);

    case (state_q)
      IDLE: begin
        if (capFire) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (accept && out_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The output register only advances when empty or being accepted, so held bytes stay stable.
    if (loadEn) begin
      out_valid_d = 1'b1;
      out_data_d  = convWord[7:0];
      out_sat_d   = convWord[8];
      out_col_d   = idx_q[IDX_W-1:0];
      out_last_d  = (idx_q == LastIdxC);
      idx_d       = idx_q + {{IDX_W{1'b0}}, 1'b1};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < N_COLS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      if (capFire) begin
        for (int i = 0; i < N_COLS; i++) begin
          bank_q[i] <= cap_data[16*i +: 16];
        end
      end
    end
  end

`ifdef FP8_SAT_CNT_EN
  logic [15:0] sat_count_q;

  // Counts accepted saturated bytes, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_q <= '0;
    end else if (accept && out_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_q <= sat_count_q + 16'd1;
    end
  end

  assign sat_count = sat_count_q;
`else
  logic unusedSat;
  assign unusedSat = out_sat_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pe_row_fp8_drain.sv
// Directed bench for pe_row_fp8_drain: conversion vectors, backpressure, back-to-back frames, mid-frame reset.
// Honours FP8_SAT_CNT_EN to check sat_count.
module tb_pe_row_fp8_drain;

  localparam int N = 8;
  localparam int IW = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic            cap_valid;
  logic            cap_ready;
  logic [16*N-1:0] cap_data;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_data;
  logic [IW-1:0]   out_col;
  logic            out_last;
  logic            busy;
`ifdef FP8_SAT_CNT_EN
  logic [15:0]     sat_count;
`endif

  int compared;
  int mismatched;

  // Column 0 sits in the least significant word / byte.
  logic [16*N-1:0] frameA;
  logic [8*N-1:0]  expA;
  logic [16*N-1:0] frameS;
  logic [8*N-1:0]  expS;

  pe_row_fp8_drain #(.N_COLS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_data  (cap_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last),
`ifdef FP8_SAT_CNT_EN
    .sat_count (sat_count),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one frame at a sample point; returns at the sample point where column 0 should be valid.
  task automatic applyStimulus(input logic [16*N-1:0] data, input bit holdValid);
    cap_data  = data;
    cap_valid = 1'b1;
    @(posedge clk); #1;
    if (!holdValid) cap_valid = 1'b0;
    checkOutput("capture busy", busy, 1);
    checkOutput("capture cap_ready", cap_ready, 0);
    checkOutput("capture out_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("first out_valid", out_valid, 1);
    checkOutput("first out_col", out_col, 0);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic drainFrame(input logic [8*N-1:0] expBytes, input int mode);
    int            got;
    logic          rdy;
    logic          prevValid;
    logic          prevReady;
    logic [7:0]    prevData;
    logic [IW-1:0] prevCol;
    logic [3:0]    pat;
    got       = 0;
    prevValid = 1'b0;
    prevReady = 1'b1;
    prevData  = '0;
    prevCol   = '0;
    pat       = 4'b1001;
    for (int cyc = 0; cyc < 200 && got < N; cyc++) begin
      rdy = (mode == 0) ? 1'b1 : pat[cyc % 4];
      out_ready = rdy;
      if (prevValid && !prevReady) begin
        checkOutput("stall valid", out_valid, 1);
        checkOutput("stall data stable", out_data, prevData);
        checkOutput("stall col stable", out_col, prevCol);
      end
      if (out_valid && rdy) begin
        checkOutput($sformatf("data col%0d", got), out_data, expBytes[8*got +: 8]);
        checkOutput($sformatf("col index %0d", got), out_col, got);
        checkOutput($sformatf("last col%0d", got), out_last, (got == N - 1));
        got++;
      end
      prevValid = out_valid;
      prevReady = rdy;
      prevData  = out_data;
      prevCol   = out_col;
      @(posedge clk); #1;
    end
    checkOutput("bytes per frame", got, N);
    checkOutput("end out_valid", out_valid, 0);
    checkOutput("end cap_ready", cap_ready, 1);
    checkOutput("end busy", busy, 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    frameA = {16'h3C80, 16'h3C00, 16'h3F98, 16'h3F88, 16'h0000, 16'hBFC0, 16'h4000, 16'h3F80};
    expA   = {8'h08, 8'h00, 8'h3A, 8'h38, 8'h00, 8'hBC, 8'h40, 8'h38};
    frameS = {16'hBFC0, 16'h4000, 16'h3F80, 16'h7F80, 16'hC47A, 16'h447A, 16'h43F8, 16'h43F0};
    expS   = {8'hBC, 8'h40, 8'h38, 8'h7F, 8'hFF, 8'h7F, 8'h7F, 8'h7F};
    rst_n     = 1'b0;
    cap_valid = 1'b0;
    cap_data  = '0;
    out_ready = 1'b0;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset cap_ready", cap_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_col", out_col, 0);
    checkOutput("reset out_last", out_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle out_valid", out_valid, 0);
    checkOutput("idle busy", busy, 0);

    $display("[TB] frame A, ready high");
    applyStimulus(frameA, 1'b0);
    drainFrame(expA, 0);
`ifdef FP8_SAT_CNT_EN
    checkOutput("sat_count after A", sat_count, 0);
`endif

    $display("[TB] saturation frame");
    applyStimulus(frameS, 1'b0);
    drainFrame(expS, 0);
`ifdef FP8_SAT_CNT_EN
    checkOutput("sat_count after S", sat_count, 4);
`endif

    $display("[TB] backpressure");
    applyStimulus(frameA, 1'b0);
    drainFrame(expA, 1);
`ifdef FP8_SAT_CNT_EN
    checkOutput("sat_count after backpressure", sat_count, 4);
`endif

    $display("[TB] cap_valid held through a frame");
    applyStimulus(frameA, 1'b1);
    cap_data = frameS;
    drainFrame(expA, 0);
    @(posedge clk); #1;
    cap_valid = 1'b0;
    checkOutput("second capture busy", busy, 1);
    checkOutput("second capture out_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("second frame out_valid", out_valid, 1);
    checkOutput("second frame out_col", out_col, 0);
    drainFrame(expS, 0);
`ifdef FP8_SAT_CNT_EN
    checkOutput("sat_count after held", sat_count, 8);
`endif

    $display("[TB] reset mid-frame");
    applyStimulus(frameA, 1'b0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre-reset out_col", out_col, 4);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", out_valid, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset cap_ready", cap_ready, 1);
`ifdef FP8_SAT_CNT_EN
    checkOutput("async reset sat_count", sat_count, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("post-reset out_valid", out_valid, 0);
      checkOutput("post-reset busy", busy, 0);
    end
    applyStimulus(frameS, 1'b0);
    drainFrame(expS, 0);
`ifdef FP8_SAT_CNT_EN
    checkOutput("sat_count after fresh frame", sat_count, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
